// File: rtl/impulse_sequencer.sv
// Impulse sequencer: free-running system time, time-triggered pulse train
// with receiver blanking and a stepped / per-period-reloaded frequency code.
// Every output is registered; the next-cycle values are computed in one
// combinational block so IMP/BLANK/DONE line up with the period counter.
module impulse_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic        SPI_WR,
  input  logic [63:0] TIME,
  input  logic        SYS_TIME_UPDATE,
  input  logic [47:0] FREQ,
  input  logic [47:0] FREQ_STEP,
  input  logic [31:0] FREQ_RATE,
  input  logic [63:0] TIME_START,
  input  logic [15:0] N_impulse,
  input  logic [7:0]  TYPE_impulse,
  input  logic [31:0] Interval_Ti,
  input  logic [31:0] Interval_Tp,
  input  logic [31:0] Tblank1,
  input  logic [31:0] Tblank2,
  output logic [63:0] SYS_TIME,
  output logic        IMP,
  output logic        BLANK,
  output logic [47:0] FREQ_OUT,
  output logic        FREQ_WR,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [15:0] IMP_CNT
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RUN} state_t;

  state_t      state, n_state;
  logic [31:0] pcnt, n_pcnt;
  logic [31:0] sc, n_sc;
  logic [15:0] n_icnt;
  logic [47:0] n_freq;
  logic        n_fwr, n_err, n_imp, n_blank, n_done, latch, period_wrap, run_nxt;
  logic        params_ok;
  logic [32:0] blank_end, blank_start;

  // shadow parameter set used by the running sequence
  logic [63:0] sh_start;
  logic [47:0] sh_freq, sh_step;
  logic [31:0] sh_rate, sh_ti, sh_tp, sh_tb1, sh_tb2;
  logic [15:0] sh_n;
  logic        sh_type0;

  // only bit 0 of the type selects behaviour; the rest is reserved
  logic unused_type;
  assign unused_type = ^TYPE_impulse[7:1];

  assign params_ok = (N_impulse != 16'd0) && (Interval_Tp != 32'd0) &&
                     (Interval_Ti != 32'd0) && (Interval_Ti <= Interval_Tp);

  // blanking window edges in 33 bits; the tail edge saturates at zero
  assign blank_end   = {1'b0, sh_ti} + {1'b0, sh_tb1};
  assign blank_start = (sh_tb2 >= sh_tp) ? 33'd0 : {1'b0, sh_tp - sh_tb2};

  // next-state / next-output computation for one enabled cycle
  always_comb begin
    n_state     = state;
    n_pcnt      = pcnt;
    n_icnt      = IMP_CNT;
    n_sc        = sc;
    n_freq      = FREQ_OUT;
    n_fwr       = 1'b0;
    n_err       = 1'b0;
    latch       = 1'b0;
    period_wrap = 1'b0;
    case (state)
      S_IDLE, S_ARMED: begin
        if (SPI_WR) begin
          if (params_ok) begin
            latch   = 1'b1;
            n_state = S_ARMED;
          end else begin
            n_err   = 1'b1;
            n_state = S_IDLE;
          end
        end else if (state == S_ARMED && SYS_TIME >= sh_start) begin
          n_state = S_RUN;
          n_pcnt  = '0;
          n_icnt  = '0;
          n_sc    = '0;
          n_freq  = sh_freq;
          n_fwr   = 1'b1;
        end
      end
      S_RUN: begin
        n_err = SPI_WR;
        if (pcnt == sh_tp - 32'd1) begin
          if (IMP_CNT == sh_n - 16'd1) begin
            n_state = S_IDLE;
          end else begin
            n_icnt      = IMP_CNT + 16'd1;
            n_pcnt      = '0;
            period_wrap = 1'b1;
          end
        end else begin
          n_pcnt = pcnt + 32'd1;
        end
        if (n_state == S_RUN) begin
          // a per-period reload takes precedence over a coincident step
          if (period_wrap && sh_type0) begin
            n_freq = sh_freq;
            n_fwr  = 1'b1;
            n_sc   = '0;
          end else if (sh_rate != 32'd0) begin
            n_sc = (sc >= sh_rate - 32'd1) ? 32'd0 : sc + 32'd1;
            if (n_sc == sh_rate - 32'd1) begin
              n_freq = FREQ_OUT + sh_step;
              n_fwr  = 1'b1;
            end
          end
        end
      end
      default: n_state = S_IDLE;
    endcase
    run_nxt = (n_state == S_RUN);
    n_imp   = run_nxt && (n_pcnt < sh_ti);
    n_blank = run_nxt && (({1'b0, n_pcnt} < blank_end) || ({1'b0, n_pcnt} >= blank_start));
    n_done  = run_nxt && (n_pcnt == sh_tp - 32'd1) && (n_icnt == sh_n - 16'd1);
  end

  // state, counters and registered outputs; strobes last one clk cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      SYS_TIME <= '0;
      pcnt     <= '0;
      sc       <= '0;
      IMP      <= 1'b0;
      BLANK    <= 1'b0;
      FREQ_OUT <= '0;
      FREQ_WR  <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      ERR      <= 1'b0;
      IMP_CNT  <= '0;
      sh_start <= '0;
      sh_freq  <= '0;
      sh_step  <= '0;
      sh_rate  <= '0;
      sh_ti    <= '0;
      sh_tp    <= '0;
      sh_tb1   <= '0;
      sh_tb2   <= '0;
      sh_n     <= '0;
      sh_type0 <= 1'b0;
    end else if (clk_en) begin
      SYS_TIME <= (SPI_WR && SYS_TIME_UPDATE) ? TIME : SYS_TIME + 64'd1;
      state    <= n_state;
      pcnt     <= n_pcnt;
      sc       <= n_sc;
      IMP      <= n_imp;
      BLANK    <= n_blank;
      FREQ_OUT <= n_freq;
      FREQ_WR  <= n_fwr;
      BUSY     <= (n_state != S_IDLE);
      DONE     <= n_done;
      ERR      <= n_err;
      IMP_CNT  <= n_icnt;
      if (latch) begin
        sh_start <= TIME_START;
        sh_freq  <= FREQ;
        sh_step  <= FREQ_STEP;
        sh_rate  <= FREQ_RATE;
        sh_ti    <= Interval_Ti;
        sh_tp    <= Interval_Tp;
        sh_tb1   <= Tblank1;
        sh_tb2   <= Tblank2;
        sh_n     <= N_impulse;
        sh_type0 <= TYPE_impulse[0];
      end
    end else begin
      FREQ_WR <= 1'b0;
      DONE    <= 1'b0;
      ERR     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_impulse_sequencer.sv
// Bench for impulse_sequencer: directed scenarios plus randomized sequences,
// checked every cycle against a run-index based reference model.
module tb_impulse_sequencer;

  logic        clk = 1'b0, rst = 1'b1, clk_en = 1'b0, SPI_WR = 1'b0, SYS_TIME_UPDATE = 1'b0;
  logic [63:0] TIME = '0, TIME_START = '0;
  logic [47:0] FREQ = '0, FREQ_STEP = '0;
  logic [31:0] FREQ_RATE = '0, Interval_Ti = '0, Interval_Tp = '0, Tblank1 = '0, Tblank2 = '0;
  logic [15:0] N_impulse = '0;
  logic [7:0]  TYPE_impulse = '0;
  logic [63:0] SYS_TIME;
  logic        IMP, BLANK, FREQ_WR, BUSY, DONE, ERR;
  logic [47:0] FREQ_OUT;
  logic [15:0] IMP_CNT;

  impulse_sequencer dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .SPI_WR(SPI_WR), .TIME(TIME),
    .SYS_TIME_UPDATE(SYS_TIME_UPDATE), .FREQ(FREQ), .FREQ_STEP(FREQ_STEP),
    .FREQ_RATE(FREQ_RATE), .TIME_START(TIME_START), .N_impulse(N_impulse),
    .TYPE_impulse(TYPE_impulse), .Interval_Ti(Interval_Ti), .Interval_Tp(Interval_Tp),
    .Tblank1(Tblank1), .Tblank2(Tblank2), .SYS_TIME(SYS_TIME), .IMP(IMP), .BLANK(BLANK),
    .FREQ_OUT(FREQ_OUT), .FREQ_WR(FREQ_WR), .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
    .IMP_CNT(IMP_CNT)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // reference model: mode 0 idle, 1 armed, 2 running at run-cycle index m_k
  int          m_mode;
  longint      m_k;
  logic [63:0] m_sys;
  logic [47:0] m_freq;
  logic [15:0] m_icnt;
  logic        m_imp, m_blank, m_fwr, m_done, m_err;
  longint      p_n, p_ti, p_tp, p_tb1, p_tb2, p_rate;
  logic        p_type0;
  logic [47:0] p_freq, p_step;
  logic [63:0] p_start;

  task automatic model_reset();
    m_mode = 0; m_k = 0; m_sys = '0; m_freq = '0; m_icnt = '0;
    m_imp = 0; m_blank = 0; m_fwr = 0; m_done = 0; m_err = 0;
  endtask

  // frequency after k run cycles: one step per FREQ_RATE cycles counted
  // from the last (re)load, the load cycle itself being the first counted
  function automatic logic [47:0] fexp(longint k);
    longint j, c;
    logic [47:0] cc;
    j  = p_type0 ? k % p_tp : k;
    c  = (p_rate == 0) ? 0 : (j + 1) / p_rate - ((p_rate == 1) ? 1 : 0);
    cc = c[47:0];
    return p_freq + p_step * cc;
  endfunction

  function automatic logic fwr_exp(longint k);
    longint j;
    j = p_type0 ? k % p_tp : k;
    return (k == 0) || (p_type0 && (k % p_tp == 0)) ||
           (p_rate != 0 && j != 0 && ((j + 1) % p_rate == 0));
  endfunction

  task automatic model_step();
    logic [63:0] old_sys;
    int old_mode;
    longint j;
    old_sys = m_sys; old_mode = m_mode;
    m_fwr = 0; m_done = 0; m_err = 0;
    if (!clk_en) return;
    m_sys = (SPI_WR && SYS_TIME_UPDATE) ? TIME : m_sys + 64'd1;
    if (SPI_WR && old_mode != 2) begin
      if (N_impulse != 0 && Interval_Tp != 0 && Interval_Ti != 0 && Interval_Ti <= Interval_Tp) begin
        p_n = N_impulse; p_ti = Interval_Ti; p_tp = Interval_Tp; p_tb1 = Tblank1; p_tb2 = Tblank2;
        p_rate = FREQ_RATE; p_type0 = TYPE_impulse[0]; p_freq = FREQ; p_step = FREQ_STEP;
        p_start = TIME_START; m_mode = 1;
      end else begin
        m_err = 1; m_mode = 0;
      end
    end else if (SPI_WR) m_err = 1;
    if (old_mode == 1 && !SPI_WR && old_sys >= p_start) begin
      m_mode = 2; m_k = 0;
    end else if (old_mode == 2) begin
      m_k++;
      if (m_k == p_n * p_tp) m_mode = 0;
    end
    if (m_mode == 2) begin
      j       = m_k % p_tp;
      m_imp   = j < p_ti;
      m_blank = (j < p_ti + p_tb1) || (j >= p_tp - p_tb2);
      m_icnt  = 16'(m_k / p_tp);
      m_done  = (m_k == p_n * p_tp - 1);
      m_freq  = fexp(m_k);
      m_fwr   = fwr_exp(m_k);
    end else begin
      m_imp = 0; m_blank = 0;
    end
  endtask

  task automatic check_all(input string pfx);
    chk({pfx, "_sys"},   SYS_TIME, m_sys);
    chk({pfx, "_imp"},   IMP,      m_imp);
    chk({pfx, "_blank"}, BLANK,    m_blank);
    chk({pfx, "_freq"},  FREQ_OUT, m_freq);
    chk({pfx, "_fwr"},   FREQ_WR,  m_fwr);
    chk({pfx, "_busy"},  BUSY,     m_mode != 0);
    chk({pfx, "_done"},  DONE,     m_done);
    chk({pfx, "_err"},   ERR,      m_err);
    chk({pfx, "_icnt"},  IMP_CNT,  m_icnt);
  endtask

  task automatic cyc(input string pfx);
    @(posedge clk);
    model_step();
    #1;
    check_all(pfx);
  endtask

  task automatic set_params(input int n, input int ti, input int tp, input int tb1, input int tb2,
                            input int rate, input logic [7:0] typ, input logic [47:0] f,
                            input logic [47:0] st, input logic [63:0] start,
                            input logic [63:0] t, input logic upd);
    N_impulse = 16'(n); Interval_Ti = 32'(ti); Interval_Tp = 32'(tp); Tblank1 = 32'(tb1);
    Tblank2 = 32'(tb2); FREQ_RATE = 32'(rate); TYPE_impulse = typ; FREQ = f; FREQ_STEP = st;
    TIME_START = start; TIME = t; SYS_TIME_UPDATE = upd;
  endtask

  task automatic write_cycle(input string pfx);
    SPI_WR = 1'b1;
    cyc(pfx);
    SPI_WR = 1'b0; SYS_TIME_UPDATE = 1'b0;
  endtask

  // en_mode: 0 always enabled, 1 toggling, 2 random; junk: SPI_WR pokes while running
  task automatic run_to_idle(input string pfx, input int en_mode, input bit junk);
    for (int i = 0; i < 600 && m_mode != 0; i++) begin
      case (en_mode)
        0: clk_en = 1'b1;
        1: clk_en = ~clk_en;
        default: clk_en = ($urandom_range(0, 3) != 0);
      endcase
      if (junk && m_mode == 2 && $urandom_range(0, 15) == 0) begin
        N_impulse = 16'($urandom); Interval_Ti = $urandom; SPI_WR = 1'b1;
      end
      cyc(pfx);
      SPI_WR = 1'b0;
    end
    chk({pfx, "_busy_end"}, BUSY, 1'b0);
  endtask

  logic [63:0] done_sys, first_imp, r64, base, st;
  logic [47:0] wq[$];
  int          imp_clks;

  initial begin
    model_reset();
    #12;
    check_all("reset");
    rst = 1'b0;
    clk_en = 1'b1;
    cyc("idle");

    // timing example: load SYS_TIME=100, start at 110
    set_params(2, 3, 8, 1, 1, 0, 8'h00, 48'd77, 48'd0, 64'd110, 64'd100, 1'b1);
    write_cycle("t039_wr");
    done_sys = '0; first_imp = '1;
    for (int i = 0; i < 100 && m_mode != 0; i++) begin
      cyc("t039");
      if (DONE) done_sys = SYS_TIME;
      if (IMP && first_imp == '1) first_imp = SYS_TIME;
    end
    chk("t039_done_time", done_sys, 64'd126);
    chk("t039_first_imp", first_imp, 64'd111);
    cyc("t039_after");
    chk("t039_busy_after", BUSY, 1'b0);

    // frequency stepping, continuous sweep then per-period reload
    for (int ty = 0; ty < 2; ty++) begin
      set_params(2, 1, 4, 0, 0, 2, 8'(ty) | 8'hA4, 48'd1000, 48'd5, SYS_TIME, 64'd0, 1'b0);
      write_cycle("tfreq_wr");
      wq.delete();
      for (int i = 0; i < 50 && m_mode != 0; i++) begin
        cyc("tfreq");
        if (FREQ_WR) wq.push_back(FREQ_OUT);
      end
      if (ty == 0) begin
        chk("t040_nwr", wq.size(), 5);
        for (int i = 0; i < wq.size() && i < 5; i++) chk("t040_val", wq[i], 48'(1000 + 5 * i));
      end else begin
        chk("t041_nwr", wq.size(), 6);
        for (int i = 0; i < wq.size() && i < 6; i++)
          chk("t041_val", wq[i], 48'(1000 + 5 * (i % 3)));
      end
    end

    // bad parameters from idle, then SPI_WR during a run
    set_params(2, 9, 8, 0, 0, 0, 8'h00, 48'd1, 48'd0, 64'd0, 64'd0, 1'b0);
    write_cycle("t042_bad");
    chk("t042_err", ERR, 1'b1);
    chk("t042_idle", BUSY, 1'b0);
    set_params(2, 2, 5, 1, 1, 1, 8'h00, 48'd50, 48'd3, SYS_TIME, 64'd0, 1'b0);
    write_cycle("t042_wr");
    for (int i = 0; i < 4; i++) cyc("t042_run");
    set_params(0, 0, 0, 0, 0, 0, 8'h00, 48'd9, 48'd9, 64'd0, 64'd0, 1'b0);
    write_cycle("t042_runwr");
    chk("t042_run_err", ERR, 1'b1);
    chk("t042_run_busy", BUSY, 1'b1);
    run_to_idle("t042_tail", 0, 0);

    // SYS_TIME wraps at 2^64
    set_params(0, 1, 1, 0, 0, 0, 8'h00, 48'd0, 48'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
    write_cycle("twrap_wr");
    cyc("twrap");
    cyc("twrap");
    chk("twrap_zero", SYS_TIME, 64'd0);

    // clock enable toggling stretches the pulse over disabled cycles
    set_params(2, 3, 8, 1, 1, 0, 8'h00, 48'd5, 48'd0, 64'd210, 64'd200, 1'b1);
    clk_en = 1'b1;
    write_cycle("t043_wr");
    imp_clks = 0;
    for (int i = 0; i < 200 && m_mode != 0; i++) begin
      clk_en = ~clk_en;
      cyc("t043");
      if (IMP && IMP_CNT == 16'd0) imp_clks++;
    end
    chk("t043_imp_clks", imp_clks, 6);
    clk_en = 1'b1;

    // asynchronous reset in the second period, then a fresh run
    set_params(2, 3, 8, 1, 1, 1, 8'h01, 48'd400, 48'd7, 64'd305, 64'd300, 1'b1);
    write_cycle("t044_wr");
    for (int i = 0; i < 100 && !(m_mode == 2 && m_k == 10); i++) cyc("t044");
    chk("t044_in_p2", IMP_CNT, 16'd1);
    #3 rst = 1'b1;
    #1;
    model_reset();
    check_all("t044_rst");
    @(posedge clk);
    #1;
    check_all("t044_rst_hold");
    rst = 1'b0;
    set_params(2, 3, 8, 1, 1, 1, 8'h01, 48'd400, 48'd7, 64'd5, 64'd0, 1'b0);
    write_cycle("t044_re_wr");
    run_to_idle("t044_rerun", 0, 0);

    // randomized sequences
    for (int t = 0; t < 40; t++) begin
      int n, ti, tp;
      logic upd;
      tp = $urandom_range(1, 6); ti = $urandom_range(1, tp); n = $urandom_range(1, 3);
      case ($urandom_range(0, 9))
        0: n = 0;
        1: ti = 0;
        2: ti = tp + 1;
        default: ;
      endcase
      r64 = {$urandom, $urandom};
      if ($urandom_range(0, 4) == 0) r64 = 64'h0000_FFFF_FFFF_FFF0;
      upd  = $urandom_range(0, 1);
      TIME = m_sys + 64'($urandom_range(0, 20));
      base = upd ? TIME : m_sys + 64'd1;
      st   = base + 64'($urandom_range(0, 10));
      if ($urandom_range(0, 2) == 0 && base >= 64'd5) st = base - 64'd5;
      set_params(n, ti, tp, $urandom_range(0, 7), $urandom_range(0, 9), $urandom_range(0, 3),
                 8'($urandom), r64[47:0], 48'({$urandom, $urandom}), st, TIME, upd);
      clk_en = ($urandom_range(0, 3) != 0);
      write_cycle("rnd_wr");
      run_to_idle("rnd", $urandom_range(0, 2), 1);
      clk_en = 1'b1;
      cyc("rnd_gap");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
